tpu_tile_sequencer: RTL and testbench

- Control sequencer for one matrix-multiply tile on the TPU datapath: Unified Buffer → systolic array → result buffer, with weights from the weight FIFO.
- On `start` it does the following in order: pops one weight tile from the weight FIFO, pulses weight reload into the systolic array, streams `num_rows` activation vectors out of the Unified Buffer, then writes each result row to the result buffer after a fixed pipeline latency.
- Replaces hand-driven `we_rl` / `fifo_read_enable` / `sram_address` at the TPU top level and produces the completion signal.

---
 rtl/tpu_tile_sequencer_if.sv | 39 +++
 rtl/tpu_tile_sequencer.sv | 208 ++++++++++++++++++++
 tb/tb_tpu_tile_sequencer.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/tpu_tile_sequencer_if.sv
// Handshake and address bus between the TPU top level and the tile sequencer.
// The master side issues tile requests and reflects the weight FIFO flag; the
// slave side is the sequencer, which produces every datapath strobe.
interface tpu_tile_sequencer_if #(
  parameter int ADDRESSSIZE = 10
);

  // Request side
  logic                   start;
  logic                   abort;
  logic [ADDRESSSIZE-1:0] src_base;
  logic [ADDRESSSIZE-1:0] dst_base;
  logic [ADDRESSSIZE-1:0] num_rows;
  logic                   fifo_empty;

  // Datapath control side
  logic                   fifo_read_enable;
  logic                   we_rl;
  logic                   ub_re;
  logic [ADDRESSSIZE-1:0] ub_addr;
  logic                   act_valid;
  logic                   res_we;
  logic [ADDRESSSIZE-1:0] res_addr;
  logic                   busy;
  logic                   done;

  modport master (
    output start, abort, src_base, dst_base, num_rows, fifo_empty,
    input  fifo_read_enable, we_rl, ub_re, ub_addr, act_valid,
           res_we, res_addr, busy, done
  );

  modport slave (
    input  start, abort, src_base, dst_base, num_rows, fifo_empty,
    output fifo_read_enable, we_rl, ub_re, ub_addr, act_valid,
           res_we, res_addr, busy, done
  );

endinterface

// File: rtl/tpu_tile_sequencer.sv
// Control sequencer for one matrix-multiply tile: pops a weight tile, pulses
// weight reload, streams num_rows activation vectors out of the Unified Buffer
// and writes each result row back after PIPE_LATENCY cycles. Every output is
// a flop; the next-cycle values are decided from the next state.
module tpu_tile_sequencer #(
  parameter int ADDRESSSIZE  = 10,
  parameter int PIPE_LATENCY = 16,
  parameter bit ABORT_EN     = 1'b1
) (
  input logic                  clk,
  input logic                  rstn,
  tpu_tile_sequencer_if.slave  bus
);

  localparam int AW = ADDRESSSIZE;
  localparam int PL = PIPE_LATENCY;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WLOAD,
    S_WLATCH,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   src_q, src_d;
  logic [AW-1:0]   dst_q, dst_d;
  logic [AW-1:0]   num_q, num_d;
  logic [AW-1:0]   iss_q, iss_d;        // activation reads issued so far
  logic [AW-1:0]   wr_q, wr_d;          // result writes issued so far
  logic [PL-1:0]   vsr_q, vsr_d;        // act_valid delay line, MSB is res_we
  logic            fre_q, fre_d;
  logic            we_rl_q, we_rl_d;
  logic            ub_re_q, ub_re_d;
  logic [AW-1:0]   ub_addr_q, ub_addr_d;
  logic            act_valid_q, act_valid_d;
  logic [AW-1:0]   res_addr_q, res_addr_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic [PL-1:0]   vsr_shift;
  logic            abort_hit;

  assign abort_hit = ABORT_EN && bus.abort;

  // Next-state, counter, delay-line and registered-output decode.
  // NOTE: every _d gets a default first so no path leaves a latch behind.
  always_comb begin
    state_d     = state_q;
    src_d       = src_q;
    dst_d       = dst_q;
    num_d       = num_q;
    iss_d       = iss_q;
    wr_d        = wr_q;
    fre_d       = 1'b0;
    we_rl_d     = 1'b0;
    ub_re_d     = 1'b0;
    ub_addr_d   = ub_addr_q;
    act_valid_d = ub_re_q;
    res_addr_d  = res_addr_q;
    done_d      = 1'b0;

    // UB data lags the read strobe by one cycle; that lagged strobe then
    // travels PIPE_LATENCY stages to become the result write strobe.
    vsr_shift = (vsr_q << 1) | PL'(act_valid_q);
    vsr_d     = vsr_shift;

    // A pulse entering the last stage is a result write next cycle; its
    // address is the base plus the writes already issued.
    if (vsr_shift[PL-1]) begin
      res_addr_d = dst_q + wr_q;
      wr_d       = wr_q + 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          src_d = bus.src_base;
          dst_d = bus.dst_base;
          num_d = bus.num_rows;
          iss_d = '0;
          wr_d  = '0;
          if (bus.num_rows == '0) begin
            // Zero rows: skip the weight load and let DRAIN see 0 == 0.
            state_d = S_DRAIN;
          end else begin
            state_d = S_WLOAD;
            fre_d   = !bus.fifo_empty;
          end
        end
      end

      S_WLOAD: begin
        // The pop strobe is already out this cycle; the tile is ours.
        if (fre_q) begin
          state_d = S_WLATCH;
          we_rl_d = 1'b1;
        end else begin
          fre_d = !bus.fifo_empty;
        end
      end

      S_WLATCH: begin
        state_d   = S_STREAM;
        ub_re_d   = 1'b1;
        ub_addr_d = src_q;
        iss_d     = {{(AW-1){1'b0}}, 1'b1};
      end

      S_STREAM: begin
        if (iss_q == num_q) begin
          state_d = S_DRAIN;
        end else begin
          ub_re_d   = 1'b1;
          ub_addr_d = src_q + iss_q;
          iss_d     = iss_q + 1'b1;
        end
      end

      S_DRAIN: begin
        if (wr_q == num_q) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort flushes everything in flight and blocks a same-cycle start.
    if (abort_hit) begin
      state_d     = S_IDLE;
      src_d       = src_q;
      dst_d       = dst_q;
      num_d       = num_q;
      iss_d       = '0;
      wr_d        = '0;
      fre_d       = 1'b0;
      we_rl_d     = 1'b0;
      ub_re_d     = 1'b0;
      ub_addr_d   = ub_addr_q;
      act_valid_d = 1'b0;
      vsr_d       = '0;
      res_addr_d  = res_addr_q;
      done_d      = 1'b0;
    end

    busy_d = (state_d != S_IDLE);
  end

  // State, captured fields, counters and registered outputs.
  // NOTE: non-blocking assignments here so every flop samples pre-edge values.
  // NOTE: the valid delay line is reset too, so no stale res_we survives reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      src_q       <= '0;
      dst_q       <= '0;
      num_q       <= '0;
      iss_q       <= '0;
      wr_q        <= '0;
      vsr_q       <= '0;
      fre_q       <= 1'b0;
      we_rl_q     <= 1'b0;
      ub_re_q     <= 1'b0;
      ub_addr_q   <= '0;
      act_valid_q <= 1'b0;
      res_addr_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      num_q       <= num_d;
      iss_q       <= iss_d;
      wr_q        <= wr_d;
      vsr_q       <= vsr_d;
      fre_q       <= fre_d;
      we_rl_q     <= we_rl_d;
      ub_re_q     <= ub_re_d;
      ub_addr_q   <= ub_addr_d;
      act_valid_q <= act_valid_d;
      res_addr_q  <= res_addr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.fifo_read_enable = fre_q;
  assign bus.we_rl            = we_rl_q;
  assign bus.ub_re            = ub_re_q;
  assign bus.ub_addr          = ub_addr_q;
  assign bus.act_valid        = act_valid_q;
  assign bus.res_we           = vsr_q[PL-1];
  assign bus.res_addr         = res_addr_q;
  assign bus.busy             = busy_q;
  assign bus.done             = done_q;

endmodule

// File: tb/tb_tpu_tile_sequencer.sv
// Self-checking bench for tpu_tile_sequencer: directed scenarios followed by
// randomized tiles, every output compared each cycle against a timeline model.
module tb_tpu_tile_sequencer;

  localparam int AW = 10;
  localparam int L  = 16;
  localparam int M  = 1 << AW;

  logic clk  = 1'b0;
  logic rstn = 1'b0;

  always #5 clk = ~clk;

  tpu_tile_sequencer_if #(.ADDRESSSIZE(AW)) bus ();

  tpu_tile_sequencer #(
    .ADDRESSSIZE (AW),
    .PIPE_LATENCY(L),
    .ABORT_EN    (1'b1)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  int compared   = 0;
  int mismatched = 0;

  task automatic check(input string tag, input int cyc,
                       input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_fre"},      0, 32'(bus.fifo_read_enable), 32'd0);
    check({tag, "_we_rl"},    0, 32'(bus.we_rl),            32'd0);
    check({tag, "_ub_re"},    0, 32'(bus.ub_re),            32'd0);
    check({tag, "_ub_addr"},  0, 32'(bus.ub_addr),          32'd0);
    check({tag, "_act_v"},    0, 32'(bus.act_valid),        32'd0);
    check({tag, "_res_we"},   0, 32'(bus.res_we),           32'd0);
    check({tag, "_res_addr"}, 0, 32'(bus.res_addr),         32'd0);
    check({tag, "_busy"},     0, 32'(bus.busy),             32'd0);
    check({tag, "_done"},     0, 32'(bus.done),             32'd0);
  endtask

  // One tile, start at relative cycle 0. fifo_empty is high for cycles
  // 0..st-1 and low at cycle st, so the pop lands at cycle st+1. ab is the
  // abort cycle (-1 none); junk is a cycle carrying a stray start (-1 none).
  task automatic run_tile(input int src, input int dst, input int n,
                          input int st, input int ab, input int junk);
    int p      = st + 1;
    int done_c = (n == 0) ? 2 : p + n + 3 + L;
    int last   = (ab >= 0) ? ab : done_c;
    for (int c = 0; c < last + 3; c++) begin
      bit live, e_fre, e_we, e_ure, e_av, e_rwe, e_busy, e_done;
      @(posedge clk);
      #1;
      bus.start = (c == 0) || (c == junk);
      bus.abort = (c == ab);
      if (c == 0) begin
        bus.src_base = AW'(src);
        bus.dst_base = AW'(dst);
        bus.num_rows = AW'(n);
      end else begin
        bus.src_base = AW'($urandom_range(0, M - 1));
        bus.dst_base = AW'($urandom_range(0, M - 1));
        bus.num_rows = AW'($urandom_range(0, M - 1));
      end
      bus.fifo_empty = (c < st) ? 1'b1 : (c == st) ? 1'b0 : 1'($urandom);
      @(negedge clk);
      live   = (ab < 0) || (c <= ab);
      e_fre  = live && n > 0 && c == p;
      e_we   = live && n > 0 && c == p + 1;
      e_ure  = live && n > 0 && c >= p + 2 && c <= p + n + 1;
      e_av   = live && n > 0 && c >= p + 3 && c <= p + n + 2;
      e_rwe  = live && n > 0 && c >= p + 3 + L && c <= p + n + 2 + L;
      e_done = live && c == done_c;
      e_busy = live && c >= 1 && c <= done_c;
      check("fifo_read_enable", c, 32'(bus.fifo_read_enable), 32'(e_fre));
      check("we_rl",            c, 32'(bus.we_rl),            32'(e_we));
      check("ub_re",            c, 32'(bus.ub_re),            32'(e_ure));
      check("act_valid",        c, 32'(bus.act_valid),        32'(e_av));
      check("res_we",           c, 32'(bus.res_we),           32'(e_rwe));
      check("busy",             c, 32'(bus.busy),             32'(e_busy));
      check("done",             c, 32'(bus.done),             32'(e_done));
      if (e_ure)
        check("ub_addr", c, 32'(bus.ub_addr), 32'((src + c - p - 2) % M));
      if (e_rwe)
        check("res_addr", c, 32'(bus.res_addr), 32'((dst + c - p - 3 - L) % M));
    end
    bus.start = 1'b0;
    bus.abort = 1'b0;
  endtask

  initial begin
    bus.start      = 1'b0;
    bus.abort      = 1'b0;
    bus.src_base   = '0;
    bus.dst_base   = '0;
    bus.num_rows   = '0;
    bus.fifo_empty = 1'b0;

    // Reset state
    #3;
    check_all_zero("reset");
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    // Basic tile
    run_tile('h010, 'h200, 4, 0, -1, -1);
    // Empty FIFO stall for 10 cycles
    run_tile('h010, 'h200, 4, 10, -1, -1);
    // Overlapping reads/writes with address wrap
    run_tile('h3FE, 'h3FF, 20, 0, -1, -1);
    // Zero rows
    run_tile('h123, 'h321, 0, 0, -1, -1);
    // Abort mid-stream at cycle 5, new start at cycle 8
    run_tile('h010, 'h200, 4, 0, 5, -1);
    run_tile('h010, 'h200, 4, 0, -1, -1);
    // Abort and start in the same IDLE cycle
    run_tile('h010, 'h200, 4, 0, 0, -1);
    // Start while busy is ignored
    run_tile('h010, 'h200, 4, 0, -1, 7);

    // Async reset in the middle of a tile
    @(posedge clk);
    #1;
    bus.start    = 1'b1;
    bus.src_base = AW'('h010);
    bus.dst_base = AW'('h200);
    bus.num_rows = AW'(4);
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk);
      #1;
      bus.start = 1'b0;
    end
    check("pre_reset_busy", 10, 32'(bus.busy), 32'd1);
    #2;
    rstn = 1'b0;
    #1;
    check_all_zero("midrst");
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    run_tile('h010, 'h200, 4, 0, -1, -1);

    // Randomized tiles
    for (int k = 0; k < 25; k++) begin
      int n    = $urandom_range(0, 40);
      int st   = $urandom_range(0, 5);
      int src  = $urandom_range(0, M - 1);
      int dst  = $urandom_range(0, M - 1);
      int mode = $urandom_range(0, 2);
      int dc   = (n == 0) ? 2 : st + 1 + n + 3 + L;
      int ab   = -1;
      int junk = -1;
      if (mode == 1) ab = $urandom_range(1, dc);
      if (mode == 2) junk = $urandom_range(1, dc);
      run_tile(src, dst, n, st, ab, junk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
